univ_mod_counter: RTL and testbench

Parametrised successor to the team's fixed 4-bit synchronous up counter. An N-bit modulo-M counter with:
- up/down direction, count enable, synchronous clear and parallel load
- selectable wrap or saturate at the range limits
- built-in prescaler
- boundary flags
Used as the general timebase/event counter in later modules (BCD digits, timers, clock dividers).

---
 rtl/counter_pkg.sv | 17 +
 rtl/mod_m_tick.sv | 41 ++++
 rtl/univ_mod_counter.sv | 83 ++++++++
 tb/tb_univ_mod_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter and timer family.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_m_tick.sv
// Prescaler: emits a one-cycle tick on every PRESCALE-th enabled cycle.
module mod_m_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_m_tick: PRESCALE must be >= 1");
  end

  if (PRESCALE == 1) begin : g_direct
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset_n, clr};
    assign tick      = en;
  end else begin : g_count
    localparam int W = clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en & (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/univ_mod_counter.sv
// N-bit modulo-M up/down counter with clear, load, wrap/saturate and prescaler.
module univ_mod_counter
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int M        = 10,
  parameter int SAT      = 0,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] Q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         roll
);

  if (M < 2 || M > (1 << N)) begin : g_bad_m
    $error("univ_mod_counter: M must satisfy 2 <= M <= 2**N");
  end

  localparam logic [N-1:0] MAX = N'(M - 1);

  logic         step;
  logic [N-1:0] q_next;
  logic         roll_next;

  // Load and clear both restart the prescale phase.
  mod_m_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .clr    (syn_clr | load),
    .tick   (step)
  );

  assign max_tick = (Q == MAX);
  assign min_tick = (Q == '0);

  always_comb begin
    q_next    = Q;
    roll_next = 1'b0;
    if (syn_clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = (d > MAX) ? MAX : d;
    end else if (step) begin
      if (up) begin
        if (Q == MAX) begin
          q_next    = (SAT == CNT_SAT) ? MAX : '0;
          roll_next = 1'b1;
        end else begin
          q_next = Q + 1'b1;
        end
      end else begin
        if (Q == '0) begin
          q_next    = (SAT == CNT_SAT) ? '0 : MAX;
          roll_next = 1'b1;
        end else begin
          q_next = Q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q    <= '0;
      roll <= 1'b0;
    end else begin
      Q    <= q_next;
      roll <= roll_next;
    end
  end

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed bench: wrap, saturate and prescaled counters share one stimulus bus.
module tb_univ_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, syn_clr, load;
  logic [3:0] d;

  logic [3:0] q0, q1, q2;
  logic       max0, min0, roll0;
  logic       max1, min1, roll1;
  logic       max2, min2, roll2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  univ_mod_counter #(.N(4), .M(10), .SAT(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .syn_clr(syn_clr),
    .load(load), .d(d), .Q(q0), .max_tick(max0), .min_tick(min0), .roll(roll0));

  univ_mod_counter #(.N(4), .M(10), .SAT(1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .syn_clr(syn_clr),
    .load(load), .d(d), .Q(q1), .max_tick(max1), .min_tick(min1), .roll(roll1));

  univ_mod_counter #(.N(4), .M(10), .SAT(0), .PRESCALE(3)) u_pre (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .syn_clr(syn_clr),
    .load(load), .d(d), .Q(q2), .max_tick(max2), .min_tick(min2), .roll(roll2));

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; up = 1'b1; syn_clr = 1'b0; load = 1'b0; d = 4'd0;
    #1;
    checks++;
    if ({q0, q1, q2} !== 12'h000) begin
      errors++; $display("FAIL reset_q: got %h %h %h, want 0 0 0", q0, q1, q2);
    end
    checks++;
    if ({roll0, roll1, roll2} !== 3'b000) begin
      errors++; $display("FAIL reset_roll: got %b%b%b, want 000", roll0, roll1, roll2);
    end
    checks++;
    if ({min0, max0, min2, max2} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags: got min=%b max=%b min2=%b max2=%b, want 1 0 1 0",
                         min0, max0, min2, max2);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    logic exp_r [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge_wait();
      checks++;
      if (q0 !== 4'(exp_q[i]) || roll0 !== exp_r[i] || max0 !== (exp_q[i] == 9)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got q=%0d roll=%b max=%b, want q=%0d roll=%b max=%b",
                 i, q0, roll0, max0, exp_q[i], exp_r[i], exp_q[i] == 9);
      end
    end
  endtask

  task automatic test_wrap_down();
    int exp_q [3] = '{9, 8, 7};
    logic exp_r [3] = '{1, 0, 0};
    syn_clr = 1'b1;
    edge_wait();
    syn_clr = 1'b0;
    checks++;
    if (q0 !== 4'd0 || min0 !== 1'b1 || roll0 !== 1'b0) begin
      errors++; $display("FAIL clr_to_zero: got q=%0d min=%b roll=%b, want 0 1 0", q0, min0, roll0);
    end
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      checks++;
      if (q0 !== 4'(exp_q[i]) || roll0 !== exp_r[i] || min0 !== 1'b0) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got q=%0d roll=%b min=%b, want q=%0d roll=%b min=0",
                 i, q0, roll0, min0, exp_q[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_q [3] = '{9, 9, 9};
    logic exp_r [3] = '{0, 1, 1};
    load = 1'b1; d = 4'd8; up = 1'b1; en = 1'b1;
    edge_wait();
    load = 1'b0;
    checks++;
    if (q1 !== 4'd8) begin
      errors++; $display("FAIL sat_load: got q=%0d, want 8", q1);
    end
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      checks++;
      if (q1 !== 4'(exp_q[i]) || roll1 !== exp_r[i] || max1 !== 1'b1) begin
        errors++;
        $display("FAIL sat_up[%0d]: got q=%0d roll=%b max=%b, want q=%0d roll=%b max=1",
                 i, q1, roll1, max1, exp_q[i], exp_r[i]);
      end
    end
    syn_clr = 1'b1;
    edge_wait();
    syn_clr = 1'b0; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_wait();
      checks++;
      if (q1 !== 4'd0 || roll1 !== 1'b1 || min1 !== 1'b1) begin
        errors++;
        $display("FAIL sat_down[%0d]: got q=%0d roll=%b min=%b, want q=0 roll=1 min=1",
                 i, q1, roll1, min1);
      end
    end
  endtask

  task automatic test_prescale();
    int run1 [5] = '{0, 0, 1, 1, 1};
    int run2 [4] = '{2, 2, 2, 3};
    syn_clr = 1'b1; up = 1'b1; en = 1'b1;
    edge_wait();
    syn_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      checks++;
      if (q2 !== 4'(run1[i])) begin
        errors++; $display("FAIL prescale_run[%0d]: got q=%0d, want %0d", i, q2, run1[i]);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      checks++;
      if (q2 !== 4'd1) begin
        errors++; $display("FAIL prescale_freeze[%0d]: got q=%0d, want 1", i, q2);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_wait();
      checks++;
      if (q2 !== 4'(run2[i])) begin
        errors++; $display("FAIL prescale_resume[%0d]: got q=%0d, want %0d", i, q2, run2[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] ld_val [4] = '{4'd13, 4'd10, 4'd9, 4'd0};
    int         ld_exp [4] = '{9, 9, 9, 0};
    syn_clr = 1'b1;
    edge_wait();
    syn_clr = 1'b0; up = 1'b1; en = 1'b1;
    repeat (5) edge_wait();
    checks++;
    if (q0 !== 4'd5) begin
      errors++; $display("FAIL prio_setup: got q=%0d, want 5", q0);
    end
    syn_clr = 1'b1; load = 1'b1; d = 4'd7;
    edge_wait();
    syn_clr = 1'b0;
    checks++;
    if (q0 !== 4'd0 || roll0 !== 1'b0) begin
      errors++; $display("FAIL prio_clr_over_load: got q=%0d roll=%b, want 0 0", q0, roll0);
    end
    for (int i = 0; i < 4; i++) begin
      d = ld_val[i];
      edge_wait();
      checks++;
      if (q0 !== 4'(ld_exp[i]) || q1 !== 4'(ld_exp[i]) || roll0 !== 1'b0) begin
        errors++;
        $display("FAIL load_clamp[d=%0d]: got q=%0d q_sat=%0d roll=%b, want %0d roll=0",
                 ld_val[i], q0, q1, roll0, ld_exp[i]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 4'd5; en = 1'b0;
    edge_wait();
    load = 1'b0; en = 1'b1; up = 1'b1;
    edge_wait();
    checks++;
    if (q0 !== 4'd6 || q2 !== 4'd5) begin
      errors++; $display("FAIL areset_setup: got q=%0d q_pre=%0d, want 6 5", q0, q2);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (q0 !== 4'd0 || roll0 !== 1'b0 || q2 !== 4'd0) begin
      errors++; $display("FAIL areset_now: got q=%0d roll=%b q_pre=%0d, want 0 0 0", q0, roll0, q2);
    end
    #1 reset_n = 1'b1;
    edge_wait();
    checks++;
    if (q0 !== 4'd1) begin
      errors++; $display("FAIL areset_first_step: got q=%0d, want 1", q0);
    end
    edge_wait();
    checks++;
    if (q2 !== 4'd0) begin
      errors++; $display("FAIL areset_prescale_phase: got q_pre=%0d, want 0", q2);
    end
    edge_wait();
    checks++;
    if (q2 !== 4'd1) begin
      errors++; $display("FAIL areset_prescale_step: got q_pre=%0d, want 1", q2);
    end

    load = 1'b1; d = 4'd9; en = 1'b0;
    edge_wait();
    load = 1'b0; en = 1'b1; up = 1'b1;
    edge_wait();
    checks++;
    if (q0 !== 4'd0 || roll0 !== 1'b1 || roll1 !== 1'b1) begin
      errors++; $display("FAIL areset_roll_setup: got q=%0d roll=%b roll_sat=%b, want 0 1 1",
                         q0, roll0, roll1);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (roll0 !== 1'b0 || roll1 !== 1'b0 || q1 !== 4'd0) begin
      errors++; $display("FAIL areset_roll: got roll=%b roll_sat=%b q_sat=%0d, want 0 0 0",
                         roll0, roll1, q1);
    end
    #1 reset_n = 1'b1;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_prescale();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
